// File: rtl/hawkes_thinning_ctrl_if.sv
// Handshake and data bundle between hawkes_thinning_ctrl, event_generator,
// the intensity unit and the timestamp consumer.
interface hawkes_thinning_ctrl_if #(
    parameter int unsigned T_WIDTH = 16
);
    logic               run;
    logic [T_WIDTH-1:0] horizon;
    logic [7:0]         D1;
    logic [7:0]         D2;
    logic               eg_start;
    logic [8:0]         eg_s;
    logic               eg_s_done;
    logic               eg_accept;
    logic               accept_pulse;
    logic [T_WIDTH-1:0] ev_time;
    logic               ev_valid;
    logic               ev_ready;
    logic [7:0]         ev_count;
    logic               busy;
    logic               finished;
    logic               wd_err;

    modport master (
        input  run, horizon, eg_s, eg_s_done, eg_accept, ev_ready,
        output D1, D2, eg_start, accept_pulse, ev_time, ev_valid, ev_count,
               busy, finished, wd_err
    );

    modport slave (
        output run, horizon, eg_s, eg_s_done, eg_accept, ev_ready,
        input  D1, D2, eg_start, accept_pulse, ev_time, ev_valid, ev_count,
               busy, finished, wd_err
    );
endinterface

// File: rtl/hawkes_thinning_ctrl.sv
// Thinning sequencer around event_generator: uniform draws, time accumulation, event FIFO.
// Optional event_generator watchdog enabled by defining HAWKES_WATCHDOG_EN.
module hawkes_thinning_ctrl #(
    parameter int unsigned T_WIDTH    = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned MAX_EVENTS = 255,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input logic                    clk,
    input logic                    rst,
    hawkes_thinning_ctrl_if.master bus
);
    localparam int unsigned PTR_W        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W        = $clog2(FIFO_DEPTH + 1);
    localparam logic [15:0] LFSR_MASK    = 16'hB400;
    localparam logic [1:0]  BLANK_CYCLES = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE, S_DRAW, S_LAUNCH, S_WAIT, S_ADVANCE, S_DECIDE, S_STALL, S_DONE
    } state_t;

    state_t             state, state_next;
    logic [15:0]        lfsr, lfsr_next;
    logic [T_WIDTH-1:0] t;
    logic [8:0]         s_cap;
    logic [1:0]         blank_cnt;
    logic [7:0]         d1_q, d2_q, ev_count_q;
    logic               eg_start_q, accept_pulse_q, busy_q, finished_q, ev_valid_q;
    logic [T_WIDTH-1:0] ev_time_q;
    logic [T_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr, rd_next;
    logic [CNT_W-1:0]   fifo_cnt, cnt_next;
    logic [T_WIDTH:0]   sum;
    logic [T_WIDTH-1:0] head_next;
    logic               launch, take_s, over, pop, full, accept, last, wd_fire;

    assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ LFSR_MASK) : (lfsr >> 1);
    assign launch    = ((state == S_IDLE) || (state == S_DONE)) && bus.run;
    assign take_s    = (state == S_WAIT) && (blank_cnt == BLANK_CYCLES) && bus.eg_s_done;
    assign sum       = {1'b0, t} + (T_WIDTH + 1)'(s_cap);
    assign over      = sum > {1'b0, bus.horizon};
    assign pop       = ev_valid_q && bus.ev_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
    assign full      = (fifo_cnt == CNT_W'(FIFO_DEPTH)) && !pop;
    assign accept    = (((state == S_DECIDE) && bus.eg_accept) || (state == S_STALL)) && !full;
    assign last      = (ev_count_q + 8'd1) == 8'(MAX_EVENTS);
    assign rd_next   = rd_ptr + PTR_W'(pop);
    assign cnt_next  = fifo_cnt + CNT_W'(accept) - CNT_W'(pop);

`ifdef HAWKES_WATCHDOG_EN
    logic [5:0] wd_cnt;
    logic       wd_err_q;

    assign wd_fire = (state == S_WAIT) && !take_s && (wd_cnt == 6'd63);

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt   <= '0;
            wd_err_q <= 1'b0;
        end else begin
            if (state == S_LAUNCH)    wd_cnt <= '0;
            else if (state == S_WAIT) wd_cnt <= wd_cnt + 6'd1;
            if (launch)               wd_err_q <= 1'b0;
            else if (wd_fire)         wd_err_q <= 1'b1;
        end
    end

    assign bus.wd_err = wd_err_q;
`else
    assign wd_fire    = 1'b0;
    assign bus.wd_err = 1'b0;
`endif

    // Next state of the sequencer.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE, S_DONE: if (bus.run) state_next = S_DRAW;
            S_DRAW:         state_next = S_LAUNCH;
            S_LAUNCH:       state_next = S_WAIT;
            S_WAIT: begin
                if (take_s)       state_next = S_ADVANCE;
                else if (wd_fire) state_next = S_DONE;
            end
            S_ADVANCE:      state_next = over ? S_DONE : S_DECIDE;
            S_DECIDE: begin
                if (!bus.eg_accept) state_next = S_DRAW;
                else if (full)      state_next = S_STALL;
                else                state_next = last ? S_DONE : S_DRAW;
            end
            S_STALL:        if (!full) state_next = last ? S_DONE : S_DRAW;
            default:        state_next = S_IDLE;
        endcase
    end

    // FIFO head after this edge's push/pop, shown fall-through; zero when empty.
    always_comb begin
        head_next = mem[rd_next];
        if (accept && (rd_next == wr_ptr)) head_next = t;
        if (cnt_next == '0)                head_next = '0;
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= t;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            lfsr           <= LFSR_SEED;
            t              <= '0;
            s_cap          <= '0;
            blank_cnt      <= '0;
            d1_q           <= '0;
            d2_q           <= '0;
            eg_start_q     <= 1'b0;
            accept_pulse_q <= 1'b0;
            ev_count_q     <= '0;
            busy_q         <= 1'b0;
            finished_q     <= 1'b0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_cnt       <= '0;
            ev_time_q      <= '0;
            ev_valid_q     <= 1'b0;
        end else begin
            state          <= state_next;
            busy_q         <= !((state_next == S_IDLE) || (state_next == S_DONE));
            finished_q     <= (state_next == S_DONE);
            eg_start_q     <= (state == S_DRAW);
            accept_pulse_q <= accept;

            if (state == S_DRAW) begin
                d1_q <= (lfsr[15:8] == 8'h00) ? 8'h01 : lfsr[15:8];
                d2_q <= lfsr[7:0];
                lfsr <= lfsr_next;
            end

            if (state == S_LAUNCH)
                blank_cnt <= '0;
            else if ((state == S_WAIT) && (blank_cnt != BLANK_CYCLES))
                blank_cnt <= blank_cnt + 2'd1;

            if (take_s) s_cap <= bus.eg_s;

            if (launch) begin
                t          <= '0;
                ev_count_q <= '0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_cnt   <= '0;
                ev_time_q  <= '0;
                ev_valid_q <= 1'b0;
            end else begin
                if ((state == S_ADVANCE) && !over) t <= sum[T_WIDTH-1:0];
                if (accept) begin
                    ev_count_q <= ev_count_q + 8'd1;
                    wr_ptr     <= wr_ptr + PTR_W'(1);
                end
                rd_ptr     <= rd_next;
                fifo_cnt   <= cnt_next;
                ev_time_q  <= head_next;
                ev_valid_q <= (cnt_next != '0);
            end
        end
    end

    assign bus.D1           = d1_q;
    assign bus.D2           = d2_q;
    assign bus.eg_start     = eg_start_q;
    assign bus.accept_pulse = accept_pulse_q;
    assign bus.ev_time      = ev_time_q;
    assign bus.ev_valid     = ev_valid_q;
    assign bus.ev_count     = ev_count_q;
    assign bus.busy         = busy_q;
    assign bus.finished     = finished_q;
endmodule

// File: doc/hawkes_thinning_ctrl.md
# hawkes_thinning_ctrl

Sequencing stage for the Hawkes Monte Carlo datapath.
- Sits directly around `event_generator`:
  - generates the uniform draws D1/D2 it consumes;
  - pulses its `start`;
  - consumes its candidate inter-arrival `s` and accept flag `done`.
- Accumulates simulated time, records accepted event timestamps in a FIFO for readout and signals the intensity unit on each acceptance.
- Stops at a time horizon or an event cap.

## Interface
Parameters:
- `T_WIDTH`, 16, simulated-time width (unsigned, same LSB scale as `s`)
- `FIFO_DEPTH`, 8, event-timestamp FIFO entries (power of 2)
- `MAX_EVENTS`, 255, event cap (≤255)
- `LFSR_SEED`, 16'hACE1, LFSR reset value (nonzero)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `run`  in  1  start request
- `horizon`  in  T_WIDTH  simulation end time
- `D1`  out  8  uniform draw to event_generator
- `D2`  out  8  uniform draw to event_generator
- `eg_start`  out  1  one-cycle start pulse to event_generator
- `eg_s`  in  9  candidate inter-arrival from event_generator
- `eg_s_done`  in  1  `s` valid (level)
- `eg_accept`  in  1  thinning accept (event_generator `done`)
- `accept_pulse`  out  1  one-cycle strobe to intensity unit
- `ev_time`  out  T_WIDTH  FIFO head timestamp
- `ev_valid`  out  1  FIFO non-empty
- `ev_ready`  in  1  consumer pop
- `ev_count`  out  8  accepted events this run
- `busy`  out  1  FSM not in IDLE/DONE
- `finished`  out  1  FSM in DONE
- `wd_err`  out  1  watchdog fired (sticky, see Configuration)

## Operation
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400), advanced once per DRAW.
  - D1 = lfsr[15:8], D2 = lfsr[7:0], both registered.
  - D1 = 0 is replaced by 8'h01 (ln(0) forbidden).
- Time register `t` (T_WIDTH bits) and `ev_count` cleared on `rst` and on run launch.
- FSM states:
  - IDLE: `run`=1 → clear t, ev_count, FIFO → DRAW.
  - DRAW: load D1/D2, step LFSR → LAUNCH.
  - LAUNCH: `eg_start`=1 for exactly one cycle → WAIT.
  - WAIT: first 2 cycles blanked (`eg_s_done` ignored). Afterwards, `eg_s_done`=1 → capture `eg_s` → ADVANCE.
  - ADVANCE: sum = t + zero-extended `eg_s`, computed T_WIDTH+1 bits wide.
    - sum > horizon (carry included) → DONE, t unchanged.
    - Otherwise t ← sum → DECIDE.
  - DECIDE: sample `eg_accept`.
    - 0 → DRAW.
    - 1 and FIFO not full → push t, ev_count+1, `accept_pulse`=1. Then → DONE if new ev_count = MAX_EVENTS, else → DRAW.
    - 1 and FIFO full → STALL.
  - STALL: wait until FIFO not full, then perform the DECIDE-accept action.
  - DONE: `finished`=1. `run`=1 → same launch as IDLE.
- `run` is ignored in all states other than IDLE and DONE.
- `eg_s`=0 is legal: t is unchanged and the event still goes to thinning.
- FIFO:
  - First-word fall-through; `ev_time` = head, `ev_valid` = non-empty.
  - Pop on `ev_valid & ev_ready`. Pop on empty is ignored.
  - Simultaneous push and pop when full: both take effect, and the FIFO stays full.
  - Clearing on run launch discards unread entries.
- Reset mid-operation: FSM → IDLE and LFSR → LFSR_SEED. All outputs return to reset values in the next cycle, and any in-flight event_generator result is discarded.

## Timing
- Reset values: D1=D2=0, eg_start=0, accept_pulse=0, ev_time=0, ev_valid=0, ev_count=0, busy=0, finished=0, wd_err=0.
- `run` high at cycle n: DRAW at n+1, `eg_start` high at n+2.
- Latency from `eg_s_done` sampled high to `accept_pulse`: 2 cycles (ADVANCE, DECIDE).
- Per-candidate overhead excluding event_generator latency: 6 cycles (DRAW, LAUNCH, 2 blanked WAIT, ADVANCE, DECIDE).
- `ev_valid` rises the cycle after the push edge; `ev_count` updates on the same edge as the push.
- `busy` and `finished` are registered state decodes, never both 1.

## Configuration
- `HAWKES_WATCHDOG_EN` defined:
  - A 6-bit counter runs in WAIT.
  - 64 cycles without `eg_s_done` → `wd_err`=1 (sticky until `rst` or run launch) and FSM → DONE.
- Undefined: no counter; WAIT waits indefinitely; `wd_err` is tied to 0.

## Test plan
- Reset then run, horizon=16'hFFFF, `eg_s_done` 4 cycles after `eg_start`, `eg_s`=9'd10, `eg_accept`=1, `ev_ready`=1 → ev_time sequence 10, 20, 30…, ev_count increments by 1 per event, D1 never 0; first D1/D2 = 8'hAC/8'hE1 stepped once, matching a reference LFSR model.
- horizon=25, `eg_s`=10, accept=1 → exactly 2 events (10, 20), then DONE with t=20 and no third `accept_pulse`.
- `eg_accept`=0 always, `eg_s`=1, horizon=5 → 0 events, DONE after 6 candidates, ev_valid never 1.
- `ev_ready`=0, FIFO_DEPTH=8, accept=1 → 8 pushes, then STALL; asserting `ev_ready` for one cycle → ninth push, count=9.
- `rst` asserted during WAIT → all outputs at reset values next cycle; a late `eg_s_done` pulse is ignored; a new `run` restarts with D1/D2 from LFSR_SEED.
- With `HAWKES_WATCHDOG_EN`, `eg_s_done` held 0 → wd_err=1 and finished=1 after 64 WAIT cycles; without the macro, busy stays 1.
